// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, fetches over an SRAM-like req/addr_ok/data_ok bus and feeds IF/ID.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned ADEL_BIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushF,
  input  logic [31:0] ExceptPC,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] InstrI,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [8:0]  ExceptTypeF,
  output logic        FetchBusyF,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StErr} state_e;

  state_e      state_q;
  logic [31:0] pc_q, req_addr_q, br_tgt_q, hold_q;
  logic        discard_q, br_pend_q;
  logic        valid, accept;
  logic [31:0] pc_next;

  assign valid = (state_q == StWait && inst_data_ok && !discard_q) ||
                 state_q == StHold || state_q == StErr;
  assign accept = valid && !StallF && !FlushF;
  // A branch resolved in the same cycle as its delay slot is handed over wins directly.
  assign pc_next = PCSrcD ? PCBranchD : (br_pend_q ? br_tgt_q : pc_q + 32'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      br_tgt_q   <= '0;
      hold_q     <= '0;
      discard_q  <= 1'b0;
      br_pend_q  <= 1'b0;
    end else if (FlushF) begin
      pc_q      <= ExceptPC;
      br_pend_q <= 1'b0;
      hold_q    <= '0;
      case (state_q)
        StReq: begin
          // The request already on the bus must complete; its data is thrown away.
          discard_q <= 1'b1;
          if (inst_addr_ok) state_q <= StWait;
        end
        StWait: begin
          if (inst_data_ok) begin
            discard_q  <= 1'b0;
            state_q    <= (ExceptPC[1:0] != 2'b00) ? StErr : StReq;
            req_addr_q <= ExceptPC;
          end else begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          discard_q  <= 1'b0;
          state_q    <= (ExceptPC[1:0] != 2'b00) ? StErr : StReq;
          req_addr_q <= ExceptPC;
        end
      endcase
    end else begin
      if (PCSrcD) begin
        br_tgt_q  <= PCBranchD;
        br_pend_q <= 1'b1;
      end
      if (accept) begin
        pc_q       <= pc_next;
        br_pend_q  <= 1'b0;
        state_q    <= (pc_next[1:0] != 2'b00) ? StErr : StReq;
        req_addr_q <= pc_next;
      end else begin
        case (state_q)
          StReq: if (inst_addr_ok) state_q <= StWait;
          StWait: begin
            if (inst_data_ok) begin
              if (discard_q) begin
                discard_q  <= 1'b0;
                state_q    <= (pc_q[1:0] != 2'b00) ? StErr : StReq;
                req_addr_q <= pc_q;
              end else begin
                hold_q  <= inst_rdata;
                state_q <= StHold;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign inst_req   = (state_q == StReq);
  assign inst_addr  = req_addr_q;
  assign PCF        = pc_q;
  assign PCPlus4F   = pc_q + 32'd4;
  assign FetchBusyF = !valid;
  assign ExceptTypeF = (state_q == StErr) ? (9'd1 << ADEL_BIT) : 9'd0;

  always_comb begin
    InstrI = '0;
    case (state_q)
      StWait:  InstrI = valid ? inst_rdata : 32'h0;
      StHold:  InstrI = hold_q;
      default: InstrI = '0;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!valid) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: the bench plays the instruction bus and keeps a
// scoreboard of fetches it has granted, compared when the stage presents them.
module tb_instr_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        StallF, FlushF, PCSrcD;
  logic [31:0] ExceptPC, PCBranchD;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [31:0] InstrI, PCF, PCPlus4F;
  logic [8:0]  ExceptTypeF;
  logic        FetchBusyF;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];  // {pc, instr} of each granted fetch expected to be delivered

  instr_fetch_stage dut (
    .clock(clock), .reset(reset), .StallF(StallF), .FlushF(FlushF), .ExceptPC(ExceptPC),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .InstrI(InstrI), .PCF(PCF), .PCPlus4F(PCPlus4F), .ExceptTypeF(ExceptTypeF),
    .FetchBusyF(FetchBusyF), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h24020001 + (a - 32'hbfc00000);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch: grant addr, optional idle WAIT cycles, data, optional stall cycles.
  // br_mode 1 = branch during first WAIT gap cycle, 2 = branch on the data cycle.
  task automatic fetch(input logic [31:0] addr, input int gap, input int stall,
                       input int br_mode, input logic [31:0] tgt);
    logic [63:0] e;
    chk("req", {31'd0, inst_req}, 32'd1);
    chk("req_addr", inst_addr, addr);
    inst_addr_ok = 1'b1;
    sb.push_back({addr, mem(addr)});
    tick();
    inst_addr_ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      PCSrcD    = (br_mode == 1 && g == 0);
      PCBranchD = tgt;
      #1;
      chk("wait_req", {31'd0, inst_req}, 32'd0);
      chk("wait_busy", {31'd0, FetchBusyF}, 32'd1);
      tick();
      PCSrcD = 1'b0;
    end
    inst_data_ok = 1'b1;
    inst_rdata   = mem(addr);
    StallF       = (stall > 0);
    PCSrcD       = (br_mode == 2);
    PCBranchD    = tgt;
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    e = (sb.size() != 0) ? sb.pop_front() : 64'h0;
    chk("data_busy", {31'd0, FetchBusyF}, 32'd0);
    chk("data_instr", InstrI, e[31:0]);
    chk("data_pc", PCF, e[63:32]);
    chk("data_pc4", PCPlus4F, e[63:32] + 32'd4);
    tick();
    inst_data_ok = 1'b0;
    PCSrcD       = 1'b0;
    inst_rdata   = 32'hdeadbeef;
    for (int s = 1; s <= stall; s++) begin
      StallF = (s < stall);
      #1;
      chk("hold_req", {31'd0, inst_req}, 32'd0);
      chk("hold_instr", InstrI, e[31:0]);
      chk("hold_busy", {31'd0, FetchBusyF}, 32'd0);
      tick();
    end
    StallF = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_fetch, exp_stall;
    reset = 1'b1;
    StallF = 1'b0; FlushF = 1'b0; PCSrcD = 1'b0;
    ExceptPC = '0; PCBranchD = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    tick(); tick();
    chk("rst_pc", PCF, 32'hbfc00000);
    chk("rst_busy", {31'd0, FetchBusyF}, 32'd1);
    chk("rst_instr", InstrI, 32'h0);
    chk("rst_exc", {23'd0, ExceptTypeF}, 32'd0);
    chk("rst_addr", inst_addr, 32'hbfc00000);
    reset = 1'b0;

    fetch(32'hbfc00000, 0, 0, 0, 32'h0);               // basic fetch
    fetch(32'hbfc00004, 1, 3, 0, 32'h0);               // stall into HOLD
    fetch(32'hbfc00008, 1, 0, 1, 32'hbfc00100);        // branch with slot in WAIT
    fetch(32'hbfc00100, 1, 0, 0, 32'h0);

    // Flush while waiting for data: the returned word must be dropped.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    FlushF = 1'b1; ExceptPC = 32'hbfc00380;
    tick();
    FlushF = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
    #1;
    chk("flw_busy", {31'd0, FetchBusyF}, 32'd1);
    chk("flw_instr", InstrI, 32'h0);
    chk("flw_pc", PCF, 32'hbfc00380);
    tick();
    inst_data_ok = 1'b0;
    fetch(32'hbfc00380, 1, 0, 0, 32'h0);

    // Flush while request not yet accepted: address held, then data dropped.
    FlushF = 1'b1; ExceptPC = 32'hbfc00400;
    tick();
    FlushF = 1'b0;
    #1;
    chk("flr_req", {31'd0, inst_req}, 32'd1);
    chk("flr_addr_held", inst_addr, 32'hbfc00384);
    chk("flr_pc", PCF, 32'hbfc00400);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
    #1;
    chk("flr_drop_busy", {31'd0, FetchBusyF}, 32'd1);
    tick();
    inst_data_ok = 1'b0;

    // Branch accepted together with its slot, to a misaligned target.
    fetch(32'hbfc00400, 0, 0, 2, 32'hbfc00102);
    StallF = 1'b1;
    #1;
    chk("err_req", {31'd0, inst_req}, 32'd0);
    chk("err_instr", InstrI, 32'h0);
    chk("err_exc", {23'd0, ExceptTypeF}, 32'd1);
    chk("err_pc", PCF, 32'hbfc00102);
    chk("err_busy", {31'd0, FetchBusyF}, 32'd0);
    tick();
    StallF = 1'b0; FlushF = 1'b1; ExceptPC = 32'hfffffffc;
    tick();
    FlushF = 1'b0;
    #1;
    chk("wrap_pc", PCF, 32'hfffffffc);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    chk("wrap_exc", {23'd0, ExceptTypeF}, 32'd0);
    fetch(32'hfffffffc, 0, 0, 0, 32'h0);

    // Reset in the middle of a transaction, then counter run.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    reset = 1'b1; inst_data_ok = 1'b1;
    tick(); tick();
    inst_data_ok = 1'b0;
    chk("rst2_pc", PCF, 32'hbfc00000);
    chk("rst2_cnt", perf_fetch_cnt, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) fetch(32'hbfc00000 + 32'(4 * i), 1, 0, 0, 32'h0);
`ifdef FETCH_PERF_EN
    exp_fetch = 32'd10; exp_stall = 32'd20;
`else
    exp_fetch = 32'd0;  exp_stall = 32'd0;
`endif
    #1;
    chk("perf_fetch", perf_fetch_cnt, exp_fetch);
    chk("perf_stall", perf_stall_cnt, exp_stall);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
